// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port synchronous SRAM controller with a
// valid/ready request side, held read response and zero-fill.
// Ports:
//   clk, rst             clock, async active-high reset
//   req_valid/req_ready  request handshake
//   req_we/adr/wdata     request (1 = write, 0 = read)
//   rsp_valid/rsp_ready  read response handshake
//   rsp_rdata            read data, stable while rsp_valid
//   clr_start/clr_busy   zero-fill request and status
//   sram_nWE/adr/din     registered SRAM controls
//   sram_dout            SRAM read data, one edge after address
module sram_ctrl #(
  parameter int AW = 2,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_adr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          sram_nWE,
  output logic [AW-1:0] sram_adr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] CAP  = 3'd3;
  localparam logic [2:0] RSP  = 3'd4;
  localparam logic [2:0] CLR  = 3'd5;

  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

  logic [2:0]    r_state;
  logic [AW:0]   r_cnt;
  logic          r_nwe;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_din;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_busy;
  logic [AW:0]   w_cnt_nxt;

  assign w_cnt_nxt = r_cnt + 1'b1;

  assign req_ready = (r_state == IDLE) & ~clr_start;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign clr_busy  = r_busy;
  assign sram_nWE  = r_nwe;
  assign sram_adr  = r_adr;
  assign sram_din  = r_din;

  // The clear drives address 0 on entry, so sram_adr always
  // equals the counter while clearing; the extra counter bit
  // keeps the last-address compare independent of wrap-around.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_nwe       <= 1'b1;
      r_adr       <= '0;
      r_din       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_state <= CLR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_nwe   <= 1'b0;
            r_adr   <= '0;
            r_din   <= '0;
          end else if (req_valid) begin
            r_adr <= req_adr;
            if (req_we) begin
              r_din   <= req_wdata;
              r_nwe   <= 1'b0;
              r_state <= WR;
            end else begin
              r_nwe   <= 1'b1;
              r_state <= RD;
            end
          end
        end
        WR: begin
          r_nwe   <= 1'b1;
          r_state <= IDLE;
        end
        RD: begin
          r_state <= CAP;
        end
        CAP: begin
          r_rsp_rdata <= sram_dout;
          r_rsp_valid <= 1'b1;
          r_state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        CLR: begin
          r_cnt <= w_cnt_nxt;
          if (r_cnt == LAST) begin
            r_nwe   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_adr <= w_cnt_nxt[AW-1:0];
          end
        end
        default: begin
          r_nwe   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl with an
// attached synchronous SRAM model (AW=4, DW=8).
module tb_sram_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [3:0] req_adr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       clr_start;
  logic       clr_busy;
  logic       sram_nWE;
  logic [3:0] sram_adr;
  logic [7:0] sram_din;
  logic [7:0] sram_dout;

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic [7:0] sb_q [$];

  int n_checks;
  int n_errors;
  int zero_seq;
  int zero_done;
  int zero_cnt;

  sram_ctrl #(.AW(4), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .sram_nWE  (sram_nWE),
    .sram_adr  (sram_adr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!sram_nWE) mem[sram_adr] <= sram_din;
    sram_dout <= mem[sram_adr];
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (zero_seq != zero_done) begin
      for (int i = 0; i < zero_cnt; i++) ref_mem[i] = 8'h00;
      zero_done = zero_seq;
    end
    if (rst) begin
      sb_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        if (req_we) ref_mem[req_adr] = req_wdata;
        else sb_q.push_back(ref_mem[req_adr]);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) check("sb_underflow", 0, 1);
        else check("rsp_data", rsp_rdata, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a,
                          input logic [7:0] d);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_adr   = a;
    req_wdata = d;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    check("wr_ready_to", n < 200, 1);
    tick();
    req_valid = 1'b0;
    check("wr_nwe_lo", sram_nWE, 0);
    check("wr_adr", sram_adr, a);
    check("wr_din", sram_din, d);
    check("wr_busy", req_ready, 0);
    tick();
    check("wr_nwe_hi", sram_nWE, 1);
  endtask

  task automatic do_read(input logic [3:0] a,
                         input int hold);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_adr   = a;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    check("rd_ready_to", n < 200, 1);
    tick();
    req_valid = 1'b0;
    check("rd_e0_valid", rsp_valid, 0);
    check("rd_e0_nwe", sram_nWE, 1);
    check("rd_e0_adr", sram_adr, a);
    tick();
    check("rd_e1_valid", rsp_valid, 0);
    check("rd_e1_ready", req_ready, 0);
    tick();
    check("rd_e2_valid", rsp_valid, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rd_hold_valid", rsp_valid, 1);
      check("rd_hold_ready", req_ready, 0);
      if (sb_q.size() != 0)
        check("rd_hold_data", rsp_rdata, sb_q[0]);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_done_valid", rsp_valid, 0);
    check("rd_idle_ready", req_ready, !req_valid);
  endtask

  task automatic do_clear();
    int n;
    n = 0;
    clr_start = 1'b1;
    #1;
    check("clr_blocks_req", req_ready, 0);
    tick();
    clr_start = 1'b0;
    while (clr_busy && n < 100) begin
      check("clr_nwe", sram_nWE, 0);
      check("clr_adr", sram_adr, n[3:0]);
      check("clr_din", sram_din, 0);
      check("clr_ready", req_ready, 0);
      n++;
      tick();
    end
    check("clr_cycles", n, 16);
    check("clr_nwe_end", sram_nWE, 1);
    zero_cnt = 16;
    zero_seq++;
  endtask

  initial begin
    int n;
    n_checks  = 0;
    n_errors  = 0;
    zero_seq  = 0;
    zero_done = 0;
    zero_cnt  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_adr   = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    clr_start = 1'b0;
    tick();
    tick();
    check("rst_nwe", sram_nWE, 1);
    check("rst_adr", sram_adr, 0);
    check("rst_din", sram_din, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_busy", clr_busy, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", req_ready, 1);

    do_write(4'd3, 8'hA5);
    do_read(4'd3, 0);

    do_write(4'd7, 8'h5A);
    do_read(4'd7, 5);

    for (int i = 0; i < 16; i++) do_write(i[3:0], 8'hFF);
    do_clear();
    do_read(4'd0, 0);
    do_read(4'd15, 0);

    do_write(4'd9, 8'h3C);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_adr   = 4'd9;
    do_clear();
    check("sim_ready_after", req_ready, 1);
    do_read(4'd9, 0);

    req_valid = 1'b1;
    req_we    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        req_adr   = 4'(i / 2 + 1);
        req_wdata = 8'(8'h11 * (i + 1));
      end
      #1;
      check("b2b_ready", req_ready, (i % 2 == 0));
      check("b2b_nwe", sram_nWE, (i % 2 == 0));
      tick();
    end
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) do_read(i[3:0], 1);

    for (int i = 0; i < 16; i++) do_write(i[3:0], 8'hFF);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (!(clr_busy && sram_adr == 4'd5) && n < 100) begin
      tick();
      n++;
    end
    check("clr5_reach", n < 100, 1);
    #1;
    rst = 1'b1;
    #1;
    check("clr5_nwe", sram_nWE, 1);
    check("clr5_busy", clr_busy, 0);
    check("clr5_rsp", rsp_valid, 0);
    tick();
    rst = 1'b0;
    zero_cnt = 5;
    zero_seq++;
    #1;
    check("clr5_ready", req_ready, 1);
    for (int i = 0; i < 16; i++) do_read(i[3:0], 0);

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_adr   = 4'd2;
    tick();
    req_valid = 1'b0;
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("rdrst_valid", rsp_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("rdrst_no_rsp", rsp_valid, 0);
    check("rdrst_ready", req_ready, 1);

    check("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The module SHALL have parameter AW, default 2, meaning address width in bits.
REQ-002 The module SHALL have parameter DW, default 2, meaning data width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 The module SHALL have port req_valid, input, 1 bit, meaning a request is offered.
REQ-006 The module SHALL have port req_ready, output, 1 bit, meaning the controller accepts the request this cycle.
REQ-007 The module SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 The module SHALL have port req_adr, input, AW bits, the request address.
REQ-009 The module SHALL have port req_wdata, input, DW bits, the write data.
REQ-010 The module SHALL have port rsp_valid, output, 1 bit, meaning read data is available.
REQ-011 The module SHALL have port rsp_ready, input, 1 bit, meaning the consumer takes the read data.
REQ-012 The module SHALL have port rsp_rdata, output, DW bits, the read data.
REQ-013 The module SHALL have port clr_start, input, 1 bit, requesting a zero-fill of the whole array.
REQ-014 The module SHALL have port clr_busy, output, 1 bit, high while a zero-fill is running.
REQ-015 The module SHALL have port sram_nWE, output, 1 bit, SRAM write enable, active-low.
REQ-016 The module SHALL have port sram_adr, output, AW bits, SRAM address.
REQ-017 The module SHALL have port sram_din, output, DW bits, SRAM write data.
REQ-018 The module SHALL have port sram_dout, input, DW bits, SRAM read data, registered in the SRAM one edge after the address is sampled.

Function
REQ-019 The controller SHALL have states IDLE, WR, RD, CAP, RSP and CLR, with all sram_* outputs registered.
REQ-020 The controller SHALL drive req_ready = (state==IDLE) & ~clr_start, and a transfer occurs on a clk edge with req_valid & req_ready.
REQ-021 In IDLE with clr_start=1, the controller SHALL enter CLR, load address counter 0, set clr_busy=1, and leave any request unaccepted.
REQ-022 On an accepted write, the controller SHALL register sram_adr=req_adr, sram_din=req_wdata and sram_nWE=0, then enter WR.
REQ-023 In WR, the controller SHALL set sram_nWE=1 and return to IDLE, giving one write per 2 cycles and no response.
REQ-024 On an accepted read, the controller SHALL register sram_adr=req_adr with sram_nWE=1 and enter RD.
REQ-025 RD SHALL go to CAP unconditionally (SRAM samples the address on this edge).
REQ-026 In CAP, the controller SHALL capture sram_dout into rsp_rdata, set rsp_valid=1 and enter RSP, so rsp_valid rises on the 2nd edge after acceptance.
REQ-027 In RSP, the controller SHALL hold rsp_valid and rsp_rdata stable until an edge with rsp_ready=1, then clear rsp_valid and enter IDLE.
REQ-028 rsp_ready SHALL be ignored outside RSP.
REQ-029 In CLR, the controller SHALL drive sram_nWE=0, sram_din=0 and sram_adr=counter, incrementing the counter each cycle from 0 to 2^AW-1.
REQ-030 After address 2^AW-1 has been driven, the controller SHALL set sram_nWE=1, clr_busy=0 and enter IDLE, for a total of 2^AW CLR cycles.
REQ-031 The CLR counter SHALL be AW+1 bits wide so termination does not depend on wrap-around.
REQ-032 clr_start outside IDLE SHALL be ignored and not queued.
REQ-033 While not writing, sram_nWE SHALL be 1, and the SRAM is never written from IDLE, RD, CAP or RSP.

Reset
REQ-034 While rst=1, the controller SHALL force state=IDLE, sram_nWE=1, sram_adr=0, sram_din=0, rsp_valid=0, rsp_rdata=0, clr_busy=0 and counter=0, asynchronously.
REQ-035 Reset asserted mid-operation (WR, RD, CAP, RSP or CLR) SHALL abort the operation immediately, with no response generated; a partial clear leaves higher addresses unmodified.
REQ-036 After rst deasserts, req_ready SHALL be 1 in the first cycle if clr_start=0.

Verification (AW=4, DW=8, model SRAM attached)
REQ-037 Write 0xA5 to adr 3, then read adr 3 -> rsp_valid rises 2 edges after read acceptance, rsp_rdata=0xA5.
REQ-038 Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held, req_ready=0 throughout, then one edge with rsp_ready=1 -> IDLE.
REQ-039 Fill all 16 addresses with 0xFF, pulse clr_start -> clr_busy high exactly 16 cycles, sram_nWE=0 on each, then reads of adr 0 and adr 15 return 0x00.
REQ-040 req_valid=1 and clr_start=1 together in IDLE -> req_ready=0, clear runs, request accepted after clr_busy falls.
REQ-041 rst asserted during CLR at counter=5 -> sram_nWE=1 at once, adr 5..15 retain 0xFF, rsp_valid=0.
REQ-042 Back-to-back writes with req_valid held high -> req_ready toggles 1,0,1,0 and each sram_nWE low pulse is exactly 1 cycle.
